// File: rtl/proc_param_pkg.sv
// proc_param shared types: opcodes, step encoding, instruction field offsets.
// Optional feature macro: PROC_MUL_EN (enables the mul instruction).
package proc_param_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4,
        OP_ONES = 3'd5,
        OP_MVNZ = 3'd6,
        OP_NOP  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam int OP_W  = 3;
    localparam int Y_LSB = 0;

    function automatic int op_lsb(input int rw);
        return 2 * rw;
    endfunction

    function automatic int x_lsb(input int rw);
        return rw;
    endfunction

endpackage

// File: rtl/proc_param_alu.sv
// proc_param ALU: add, sub, optional mul and popcount, all modulo 2^DATA_W.
// Optional feature macro: PROC_MUL_EN (multiplier only exists when defined).
module proc_param_alu
    import proc_param_pkg::*;
#(
    parameter int DATA_W = 9
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] ones;

    // Count the set bits of the bus operand.
    always_comb begin
        ones = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ones = ones + DATA_W'(b[i]);
        end
    end

    // Pick the result for the decoded operation.
    always_comb begin
        y = '0;
        case (opcode_e'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
`ifdef PROC_MUL_EN
            OP_MUL:  y = a * b;
`endif
            OP_ONES: y = ones;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/proc_param.sv
// proc_param: parametrised multicycle processor (step FSM, decoder, bus, regs).
// Optional feature macro: PROC_MUL_EN (opcode 100 is mul, else nop).
module proc_param
    import proc_param_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int NREG   = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic [DATA_W-1:0]        DIN,
    output logic                     Fetch,
    output logic                     Done,
    output logic [DATA_W-1:0]        BusWires,
    output logic [NREG*DATA_W-1:0]   Reg_out,
    output logic [DATA_W-1:0]        RA_out,
    output logic [DATA_W-1:0]        RG_out,
    output logic [DATA_W-1:0]        IR_out,
    output logic [1:0]               Tstep_state
);

    localparam int RW     = $clog2(NREG);
    localparam int OP_LSB = op_lsb(RW);
    localparam int X_LSB  = x_lsb(RW);

    tstep_e            step;
    tstep_e            step_nxt;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rg;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_y;
    logic [RW-1:0]     rx;
    logic [RW-1:0]     ry;
    opcode_e           op;
    logic              ir_ld;
    logic              a_ld;
    logic              g_ld;
    logic              rx_ld;

    assign rx = ir[X_LSB +: RW];
    assign ry = ir[Y_LSB +: RW];

    // Decode the opcode; without the multiplier, mul behaves as nop.
    always_comb begin
        op = opcode_e'(ir[OP_LSB +: OP_W]);
`ifndef PROC_MUL_EN
        if (op == OP_MUL) begin
            op = OP_NOP;
        end
`endif
    end

    // Step sequencing, bus source selection and load enables.
    always_comb begin
        step_nxt = step;
        Fetch    = 1'b0;
        Done     = 1'b0;
        bus      = '0;
        ir_ld    = 1'b0;
        a_ld     = 1'b0;
        g_ld     = 1'b0;
        rx_ld    = 1'b0;
        unique case (step)
            T0: begin
                if (Run) begin
                    Fetch    = 1'b1;
                    ir_ld    = 1'b1;
                    step_nxt = T1;
                end
            end
            T1: begin
                step_nxt = T0;
                case (op)
                    OP_MV: begin
                        bus   = regs[ry];
                        rx_ld = 1'b1;
                        Done  = 1'b1;
                    end
                    OP_MVI: begin
                        bus   = DIN;
                        Fetch = 1'b1;
                        rx_ld = 1'b1;
                        Done  = 1'b1;
                    end
                    OP_MVNZ: begin
                        bus   = regs[ry];
                        rx_ld = (rg != '0);
                        Done  = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_MUL: begin
                        bus      = regs[rx];
                        a_ld     = 1'b1;
                        step_nxt = T2;
                    end
                    OP_ONES: begin
                        bus      = regs[ry];
                        g_ld     = 1'b1;
                        step_nxt = T2;
                    end
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                step_nxt = T0;
                case (op)
                    OP_ADD, OP_SUB, OP_MUL: begin
                        bus      = regs[ry];
                        g_ld     = 1'b1;
                        step_nxt = T3;
                    end
                    OP_ONES: begin
                        bus   = rg;
                        rx_ld = 1'b1;
                        Done  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                bus      = rg;
                rx_ld    = 1'b1;
                Done     = 1'b1;
                step_nxt = T0;
            end
        endcase
    end

    proc_param_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op),
        .a  (ra),
        .b  (bus),
        .y  (alu_y)
    );

    // State, instruction, A, G and register file updates.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            step <= T0;
            ir   <= '0;
            ra   <= '0;
            rg   <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            step <= step_nxt;
            if (ir_ld) ir <= DIN;
            if (a_ld) ra <= bus;
            if (g_ld) rg <= alu_y;
            if (rx_ld) regs[rx] <= bus;
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign Reg_out[i*DATA_W +: DATA_W] = regs[i];
    end

    assign BusWires    = bus;
    assign RA_out      = ra;
    assign RG_out      = rg;
    assign IR_out      = ir;
    assign Tstep_state = step;

endmodule

// File: tb/tb_proc_param.sv
// Self-checking bench for proc_param: directed table, reset corner cases,
// and random programs against a behavioural model (9x8 and 12x4 builds).
module tb_proc_param;

`ifdef PROC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk;
    logic rst_a, run_a, fetch_a, done_a;
    logic [8:0] din_a, bus_a, ra_a, rg_a, ir_a;
    logic [71:0] reg_a;
    logic [1:0] st_a;

    logic rst_b, run_b, fetch_b, done_b;
    logic [11:0] din_b, bus_b, ra_b, rg_b, ir_b;
    logic [47:0] reg_b;
    logic [1:0] st_b;

    proc_param dut_a (
        .Clock(clk), .Reset(rst_a), .Run(run_a), .DIN(din_a),
        .Fetch(fetch_a), .Done(done_a), .BusWires(bus_a),
        .Reg_out(reg_a), .RA_out(ra_a), .RG_out(rg_a),
        .IR_out(ir_a), .Tstep_state(st_a)
    );

    proc_param #(.DATA_W(12), .NREG(4)) dut_b (
        .Clock(clk), .Reset(rst_b), .Run(run_b), .DIN(din_b),
        .Fetch(fetch_b), .Done(done_b), .BusWires(bus_b),
        .Reg_out(reg_b), .RA_out(ra_b), .RG_out(rg_b),
        .IR_out(ir_b), .Tstep_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit sel;
    logic done_s, fetch_s;
    logic [11:0] g_s, a_s, ir_s, bus_s;
    logic [1:0] st_s;

    always_comb begin
        if (sel) begin
            done_s = done_b; fetch_s = fetch_b; g_s = rg_b; a_s = ra_b;
            ir_s = ir_b; bus_s = bus_b; st_s = st_b;
        end else begin
            done_s = done_a; fetch_s = fetch_a; g_s = {3'b0, rg_a};
            a_s = {3'b0, ra_a}; ir_s = {3'b0, ir_a};
            bus_s = {3'b0, bus_a}; st_s = st_a;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [11:0] rd(input int i);
        if (sel) return reg_b[i*12 +: 12];
        return {3'b0, reg_a[i*9 +: 9]};
    endfunction

    function automatic int nreg_s();
        return sel ? 4 : 8;
    endfunction

    task automatic drive(input logic r, input logic [11:0] d);
        if (sel) begin run_b = r; din_b = d; end
        else begin run_a = r; din_a = d[8:0]; end
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst_b = v; else rst_a = v;
    endtask

    // Issue one instruction; report cycles to Done and Fetch cycles seen.
    task automatic exec(input logic [11:0] ins, input logic [11:0] imm,
                        output int lat, output int nf);
        lat = 0;
        nf  = 0;
        @(negedge clk);
        drive(1'b1, ins);
        #1 nf += int'(fetch_s);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), imm);
            #1 nf += int'(fetch_s);
            if (done_s) begin
                drive(1'b0, imm);
                lat = c + 1;
                break;
            end
        end
        @(posedge clk);
    endtask

    logic [11:0] mr [8];
    logic [11:0] mg, ma;

    task automatic mreset();
        for (int i = 0; i < 8; i++) mr[i] = '0;
        mg = '0;
        ma = '0;
    endtask

    // Architectural effect of one instruction, from the instruction set.
    task automatic model_exec(input logic [11:0] ins, input logic [11:0] imm,
                              output int lat, output int nf);
        int rw, op, x, y;
        logic [11:0] mask;
        rw   = sel ? 2 : 3;
        mask = sel ? 12'hFFF : 12'h1FF;
        op   = int'(ins >> (2 * rw)) & 7;
        x    = int'(ins >> rw) & ((1 << rw) - 1);
        y    = int'(ins) & ((1 << rw) - 1);
        lat  = 2;
        nf   = 1;
        case (op)
            0: mr[x] = mr[y];
            1: begin mr[x] = imm & mask; nf = 2; end
            2, 3, 4: begin
                if (op != 4 || MUL_EN) begin
                    ma = mr[x];
                    if (op == 2) mg = (mr[x] + mr[y]) & mask;
                    else if (op == 3) mg = (mr[x] - mr[y]) & mask;
                    else mg = (mr[x] * mr[y]) & mask;
                    mr[x] = mg;
                    lat = 4;
                end
            end
            5: begin mg = 12'($countones(mr[y])); mr[x] = mg; lat = 3; end
            6: if (mg != 0) mr[x] = mr[y];
            default: ;
        endcase
    endtask

    task automatic exec_model(input logic [11:0] ins, input logic [11:0] imm);
        int lat, nf, elat, enf;
        model_exec(ins, imm, elat, enf);
        exec(ins, imm, lat, nf);
        @(negedge clk);
        for (int i = 0; i < nreg_s(); i++) check($sformatf("rnd R%0d", i), rd(i), mr[i]);
        check("rnd G", g_s, mg);
        check("rnd A", a_s, ma);
        check("rnd latency", lat, elat);
        check("rnd fetch", nf, enf);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < nreg_s(); i++) check($sformatf("%s R%0d", tag, i), rd(i), 0);
        check({tag, " A"}, a_s, 0);
        check({tag, " G"}, g_s, 0);
        check({tag, " IR"}, ir_s, 0);
        check({tag, " step"}, st_s, 0);
        check({tag, " Done"}, done_s, 0);
        check({tag, " Fetch"}, fetch_s, 0);
        check({tag, " bus"}, bus_s, 0);
    endtask

    // Start an add, assert Reset (with Run) in its T2 step.
    task automatic reset_mid(input logic [11:0] ins, input string tag);
        @(negedge clk);
        drive(1'b1, ins);
        @(negedge clk);
        drive(1'b0, 12'h0);
        @(negedge clk);
        #1 check({tag, " in T2"}, st_s, 2);
        set_rst(1'b1);
        drive(1'b1, ins);
        @(negedge clk);
        set_rst(1'b0);
        drive(1'b0, 12'h0);
        #1 check_zero(tag);
        mreset();
    endtask

    typedef struct {
        logic [11:0] ins;
        logic [11:0] imm;
        int          idx;
        logic [11:0] er;
        logic [11:0] eg;
        int          lat;
        int          nf;
    } vec_t;

    vec_t tv [17];

    initial begin
        int lat, nf;
        logic [11:0] gm, r4;
        gm = MUL_EN ? 12'd36 : 12'd0;
        r4 = MUL_EN ? 12'd36 : 12'd6;
        tv[0]  = '{12'o100, 12'd6,   0, 12'd6,   12'd0,   2, 2};
        tv[1]  = '{12'o030, 12'd0,   3, 12'd6,   12'd0,   2, 1};
        tv[2]  = '{12'o140, 12'd6,   4, 12'd6,   12'd0,   2, 2};
        tv[3]  = '{12'o444, 12'd0,   4, r4,      gm,      MUL_EN ? 4 : 2, 1};
        tv[4]  = '{12'o110, 12'd0,   1, 12'd0,   gm,      2, 2};
        tv[5]  = '{12'o310, 12'd0,   1, 12'd506, 12'd506, 4, 1};
        tv[6]  = '{12'o150, 12'd511, 5, 12'd511, 12'd506, 2, 2};
        tv[7]  = '{12'o565, 12'd0,   6, 12'd9,   12'd9,   3, 1};
        tv[8]  = '{12'o333, 12'd0,   3, 12'd0,   12'd0,   4, 1};
        tv[9]  = '{12'o170, 12'd5,   7, 12'd5,   12'd0,   2, 2};
        tv[10] = '{12'o627, 12'd0,   2, 12'd0,   12'd0,   2, 1};
        tv[11] = '{12'o130, 12'd1,   3, 12'd1,   12'd0,   2, 2};
        tv[12] = '{12'o140, 12'd2,   4, 12'd2,   12'd0,   2, 2};
        tv[13] = '{12'o234, 12'd0,   3, 12'd3,   12'd3,   4, 1};
        tv[14] = '{12'o627, 12'd0,   2, 12'd5,   12'd3,   2, 1};
        tv[15] = '{12'o700, 12'd0,   2, 12'd5,   12'd3,   2, 1};
        tv[16] = '{12'o022, 12'd0,   2, 12'd5,   12'd3,   2, 1};

        sel = 1'b0;
        rst_a = 1'b1; run_a = 1'b0; din_a = '0;
        rst_b = 1'b1; run_b = 1'b0; din_b = '0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1 check_zero("reset");

        foreach (tv[k]) begin
            exec(tv[k].ins, tv[k].imm, lat, nf);
            @(negedge clk);
            check($sformatf("vec%0d R%0d", k, tv[k].idx), rd(tv[k].idx), tv[k].er);
            check($sformatf("vec%0d G", k), g_s, tv[k].eg);
            check($sformatf("vec%0d latency", k), lat, tv[k].lat);
            check($sformatf("vec%0d fetch", k), nf, tv[k].nf);
        end

        reset_mid(12'o234, "midreset9");

        for (int k = 0; k < 150; k++) begin
            exec_model(12'($urandom_range(0, 511)), 12'($urandom_range(0, 511)));
        end

        sel = 1'b1;
        set_rst(1'b1);
        @(negedge clk);
        set_rst(1'b0);
        mreset();
        exec_model(12'h010, 12'd2047);
        exec_model(12'h014, 12'd1);
        exec_model(12'h021, 12'd0);
        check("w12 add R0", rd(0), 12'd2048);
        check("w12 add G", g_s, 12'd2048);
        reset_mid(12'h021, "midreset12");

        for (int k = 0; k < 100; k++) begin
            exec_model(12'($urandom), 12'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
